// File: rtl/audio_tone_monitor.sv
// Tone checker for one audio channel: moving-average smoothing, period and peak
// measurement between rising zero crossings, window checks and saturating error counts.
module audio_tone_monitor #(
    parameter int AVG_LOG2   = 2,
    parameter int CNT_W      = 12,
    parameter int MIN_PERIOD = 573,
    parameter int MAX_PERIOD = 953,
    parameter int MIN_AMPL   = 2400,
    parameter int MAX_AMPL   = 4000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    smpl_vld,
    input  logic signed [15:0]      smpl_in,
    input  logic                    clr_errs,
    output logic                    meas_vld,
    output logic [CNT_W-1:0]        period,
    output logic signed [15:0]      peak,
    output logic                    freq_err,
    output logic                    ampl_err,
    output logic [7:0]              freq_err_cnt,
    output logic [7:0]              ampl_err_cnt,
    output logic                    locked
);

    // state   | meaning
    // WARM    | filling the averager, crossings ignored
    // ARM     | waiting for the first rising crossing
    // MEASURE | timing periods between rising crossings
    typedef enum logic [1:0] {WARM, ARM, MEASURE} state_t;

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 16 + AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic signed [15:0]      hist_q [DEPTH];
    logic signed [15:0]      hist_d [DEPTH];
    logic [AVG_LOG2-1:0]     wr_ptr_q, wr_ptr_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    avg_vld_q, avg_vld_d;
    logic signed [15:0]      avg;
    logic                    prev_neg_q, prev_neg_d;
    logic                    crossing;

    state_t                  state_q, state_d;
    logic [AVG_LOG2-1:0]     warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic signed [15:0]      peak_acc_q, peak_acc_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic signed [15:0]      peak_q, peak_d;
    logic                    freq_err_q, freq_err_d;
    logic                    ampl_err_q, ampl_err_d;
    logic                    meas_vld_q, meas_vld_d;
    logic [7:0]              freq_err_cnt_q, freq_err_cnt_d;
    logic [7:0]              ampl_err_cnt_q, ampl_err_cnt_d;
    logic                    freq_bad, ampl_bad;

    always_comb begin
        hist_d    = hist_q;
        wr_ptr_d  = wr_ptr_q;
        sum_d     = sum_q;
        avg_vld_d = smpl_vld;
        if (smpl_vld) begin
            hist_d[wr_ptr_q] = smpl_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            sum_d            = sum_q + SUM_W'(smpl_in) - SUM_W'(hist_q[wr_ptr_q]);
        end
    end

    // Taking 16 bits above the fraction is the arithmetic shift, rounding toward -inf.
    assign avg      = sum_q[AVG_LOG2 +: 16];
    assign crossing = avg_vld_q & prev_neg_q & ~avg[15];

    always_comb begin
        prev_neg_d = prev_neg_q;
        if (avg_vld_q) prev_neg_d = avg[15];
    end

    assign cnt_inc  = cnt_q + 1'b1;
    assign freq_bad = (int'(cnt_inc) < MIN_PERIOD) || (int'(cnt_inc) > MAX_PERIOD);
    assign ampl_bad = (int'(peak_acc_q) < MIN_AMPL) || (int'(peak_acc_q) > MAX_AMPL);

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        cnt_d      = cnt_q;
        peak_acc_d = peak_acc_q;
        period_d   = period_q;
        peak_d     = peak_q;
        freq_err_d = freq_err_q;
        ampl_err_d = ampl_err_q;
        meas_vld_d = 1'b0;
        case (state_q)
            WARM: begin
                if (avg_vld_q) begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                    if (warm_cnt_q == '1) state_d = ARM;
                end
            end
            ARM: begin
                if (crossing) begin
                    cnt_d      = '0;
                    peak_acc_d = avg;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                if (crossing) begin
                    meas_vld_d = 1'b1;
                    period_d   = cnt_inc;
                    peak_d     = peak_acc_q;
                    freq_err_d = freq_bad;
                    ampl_err_d = ampl_bad;
                    cnt_d      = '0;
                    peak_acc_d = avg;
                end else if (avg_vld_q && (cnt_inc == CNT_MAX)) begin
                    meas_vld_d = 1'b1;
                    period_d   = CNT_MAX;
                    peak_d     = peak_acc_q;
                    freq_err_d = 1'b1;
                    ampl_err_d = ampl_bad;
                    state_d    = ARM;
                end else if (avg_vld_q) begin
                    cnt_d = cnt_inc;
                    if (avg > peak_acc_q) peak_acc_d = avg;
                end
            end
            default: state_d = WARM;
        endcase
    end

    // A clear that lands on an error edge keeps that one error.
    always_comb begin
        freq_err_cnt_d = freq_err_cnt_q;
        ampl_err_cnt_d = ampl_err_cnt_q;
        if (clr_errs) begin
            freq_err_cnt_d = (meas_vld_d && freq_err_d) ? 8'd1 : 8'd0;
            ampl_err_cnt_d = (meas_vld_d && ampl_err_d) ? 8'd1 : 8'd0;
        end else begin
            if (meas_vld_d && freq_err_d && (freq_err_cnt_q != 8'hFF))
                freq_err_cnt_d = freq_err_cnt_q + 8'd1;
            if (meas_vld_d && ampl_err_d && (ampl_err_cnt_q != 8'hFF))
                ampl_err_cnt_d = ampl_err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
            wr_ptr_q       <= '0;
            sum_q          <= '0;
            avg_vld_q      <= 1'b0;
            prev_neg_q     <= 1'b0;
            state_q        <= WARM;
            warm_cnt_q     <= '0;
            cnt_q          <= '0;
            peak_acc_q     <= '0;
            period_q       <= '0;
            peak_q         <= '0;
            freq_err_q     <= 1'b0;
            ampl_err_q     <= 1'b0;
            meas_vld_q     <= 1'b0;
            freq_err_cnt_q <= '0;
            ampl_err_cnt_q <= '0;
        end else begin
            hist_q         <= hist_d;
            wr_ptr_q       <= wr_ptr_d;
            sum_q          <= sum_d;
            avg_vld_q      <= avg_vld_d;
            prev_neg_q     <= prev_neg_d;
            state_q        <= state_d;
            warm_cnt_q     <= warm_cnt_d;
            cnt_q          <= cnt_d;
            peak_acc_q     <= peak_acc_d;
            period_q       <= period_d;
            peak_q         <= peak_d;
            freq_err_q     <= freq_err_d;
            ampl_err_q     <= ampl_err_d;
            meas_vld_q     <= meas_vld_d;
            freq_err_cnt_q <= freq_err_cnt_d;
            ampl_err_cnt_q <= ampl_err_cnt_d;
        end
    end

    assign meas_vld     = meas_vld_q;
    assign period       = period_q;
    assign peak         = peak_q;
    assign freq_err     = freq_err_q;
    assign ampl_err     = ampl_err_q;
    assign freq_err_cnt = freq_err_cnt_q;
    assign ampl_err_cnt = ampl_err_cnt_q;
    assign locked       = (state_q == MEASURE);

endmodule

// File: tb/tb_audio_tone_monitor.sv
// Directed bench for audio_tone_monitor: square-wave tones with hand-computed
// periods, peaks, flags and counter values.
module tb_audio_tone_monitor;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               smpl_vld = 1'b0;
    logic signed [15:0] smpl_in = '0;
    logic               clr_errs = 1'b0;
    logic               meas_vld;
    logic [7:0]         period;
    logic signed [15:0] peak;
    logic               freq_err, ampl_err, locked;
    logic [7:0]         freq_err_cnt, ampl_err_cnt;

    audio_tone_monitor #(
        .AVG_LOG2(2), .CNT_W(8), .MIN_PERIOD(90), .MAX_PERIOD(110),
        .MIN_AMPL(800), .MAX_AMPL(1200)
    ) dut (
        .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_in(smpl_in),
        .clr_errs(clr_errs), .meas_vld(meas_vld), .period(period), .peak(peak),
        .freq_err(freq_err), .ampl_err(ampl_err), .freq_err_cnt(freq_err_cnt),
        .ampl_err_cnt(ampl_err_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int peak;
        int fe;
        int ae;
        int lk;
        int fc;
        int ac;
        int cyc;
    } meas_t;

    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    xc;
    meas_t mrec;
    meas_t mq[$];
    int    samp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_vld === 1'b1) begin
            mrec.period = int'(period);
            mrec.peak   = int'($unsigned(peak));
            mrec.fe     = int'(freq_err);
            mrec.ae     = int'(ampl_err);
            mrec.lk     = int'(locked);
            mrec.fc     = int'(freq_err_cnt);
            mrec.ac     = int'(ampl_err_cnt);
            mrec.cyc    = cyc;
            mq.push_back(mrec);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic send(input int v);
        smpl_in  = 16'(v);
        smpl_vld = 1'b1;
        samp_cyc.push_back(cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        smpl_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic square(input int amp, input int half, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < half; i++) send(-amp);
            for (int i = 0; i < half; i++) send(amp);
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_meas_vld", int'(meas_vld), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_peak", int'($unsigned(peak)), 0);
        chk("rst_flags", int'({freq_err, ampl_err}), 0);
        chk("rst_cnts", int'({freq_err_cnt, ampl_err_cnt}), 0);
        chk("rst_locked", int'(locked), 0);
        rst = 1'b0;
        idle(2);

        // nominal tone: crossings at samples 51,151,251,351,451
        mq.delete(); samp_cyc.delete();
        square(1000, 50, 5);
        idle(3);
        chk("nom_count", mq.size(), 4);
        foreach (mq[i]) begin
            chk("nom_period", mq[i].period, 100);
            chk("nom_peak", mq[i].peak, 1000);
            chk("nom_flags", mq[i].fe + mq[i].ae, 0);
            chk("nom_cnts", mq[i].fc + mq[i].ac, 0);
        end
        if (mq.size() > 0) chk("nom_latency", mq[0].cyc, samp_cyc[151] + 2);
        chk("nom_locked", int'(locked), 1);

        // amplitude fault: first period still spans the 1000 tone
        mq.delete();
        square(2000, 50, 4);
        idle(3);
        chk("amp_count", mq.size(), 4);
        if (mq.size() == 4) begin
            chk("amp_first_peak", mq[0].peak, 1000);
            chk("amp_first_ae", mq[0].ae, 0);
            for (int i = 1; i < 4; i++) begin
                chk("amp_period", mq[i].period, 100);
                chk("amp_peak", mq[i].peak, 2000);
                chk("amp_ae", mq[i].ae, 1);
                chk("amp_fe", mq[i].fe, 0);
                chk("amp_cnt", mq[i].ac, i);
            end
        end

        // frequency fault: first period 48+32 samples with 2000 peak
        mq.delete();
        square(1000, 30, 4);
        idle(3);
        chk("frq_count", mq.size(), 4);
        if (mq.size() == 4) begin
            chk("frq_first_period", mq[0].period, 80);
            chk("frq_first_peak", mq[0].peak, 2000);
            chk("frq_first_flags", mq[0].fe * 2 + mq[0].ae, 3);
            for (int i = 1; i < 4; i++) begin
                chk("frq_period", mq[i].period, 60);
                chk("frq_peak", mq[i].peak, 1000);
                chk("frq_fe", mq[i].fe, 1);
                chk("frq_ae", mq[i].ae, 0);
                chk("frq_fcnt", mq[i].fc, 1 + i);
                chk("frq_acnt", mq[i].ac, 4);
            end
        end

        // timeout: cnt is 28 at entry, fires on the 227th +500 sample
        mq.delete(); samp_cyc.delete();
        repeat (300) send(500);
        idle(3);
        chk("to_count", mq.size(), 1);
        if (mq.size() == 1) begin
            chk("to_period", mq[0].period, 255);
            chk("to_peak", mq[0].peak, 1000);
            chk("to_fe", mq[0].fe, 1);
            chk("to_ae", mq[0].ae, 0);
            chk("to_locked_at_meas", mq[0].lk, 0);
            chk("to_fcnt", mq[0].fc, 5);
            chk("to_latency", mq[0].cyc, samp_cyc[226] + 2);
        end
        chk("to_unlocked", int'(locked), 0);

        // re-lock on the next crossing without a measurement
        mq.delete();
        repeat (4) send(-500);
        repeat (10) send(500);
        idle(3);
        chk("relock_no_meas", mq.size(), 0);
        chk("relock_locked", int'(locked), 1);

        // saturation: 300 faulted periods of 20 samples
        mq.delete();
        square(2000, 10, 300);
        idle(3);
        chk("sat_count", mq.size(), 300);
        if (mq.size() > 0) begin
            chk("sat_first_period", mq[0].period, 20);
            chk("sat_first_peak", mq[0].peak, 500);
        end
        chk("sat_acnt", int'(ampl_err_cnt), 255);
        chk("sat_fcnt", int'(freq_err_cnt), 255);

        clr_errs = 1'b1;
        idle(1);
        clr_errs = 1'b0;
        chk("clr_acnt", int'(ampl_err_cnt), 0);
        chk("clr_fcnt", int'(freq_err_cnt), 0);

        // clear coincident with a faulted measurement keeps that one
        mq.delete(); samp_cyc.delete();
        repeat (10) send(-2000);
        send(2000);
        send(2000);
        xc = samp_cyc[11];
        clr_errs = 1'b1;
        send(2000);
        clr_errs = 1'b0;
        idle(3);
        chk("clr_hit_count", mq.size(), 1);
        if (mq.size() == 1) chk("clr_hit_latency", mq[0].cyc, xc + 2);
        chk("clr_hit_acnt", int'(ampl_err_cnt), 1);
        chk("clr_hit_fcnt", int'(freq_err_cnt), 1);

        // asynchronous reset mid-period with samples still streaming
        smpl_in  = 16'sd1000;
        smpl_vld = 1'b1;
        rst      = 1'b1;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_flags", int'({meas_vld, freq_err, ampl_err}), 0);
        chk("arst_cnts", int'({freq_err_cnt, ampl_err_cnt}), 0);
        chk("arst_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); samp_cyc.delete();
        square(1000, 50, 2);
        idle(3);
        chk("arst_meas_count", mq.size(), 1);
        if (mq.size() == 1) begin
            chk("arst_latency", mq[0].cyc, samp_cyc[151] + 2);
            chk("arst_period_after", mq[0].period, 100);
            chk("arst_peak_after", mq[0].peak, 1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
